gcd_useq: RTL and testbench
===========================

# gcd_useq

Microprogram sequencer for the GCD datapath. Holds the micro-PC and drives the 4-bit address of the combinational microcode ROM. Decodes the returned 24-bit microword into datapath control signals. Resolves branches from the start input and the ALU zero/negative flags. Adds start edge detection, a halt input, illegal-opcode detection and a watchdog. Sits between the top-level start/done interface and the ROM + register-file/ALU datapath.

## Interface
- `WDOG_MAX`, default 255: busy cycles allowed before a forced abort; 0 disables the watchdog.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: run request; level input, only rising edges are acted on.
- `halt`  in  1: freeze sequencing.
- `alu_zero`  in  1: ALU result == 0, combinational, same cycle.
- `alu_neg`  in  1: ALU result MSB, combinational, same cycle.
- `rom_q`  in  24: microword for `rom_addr`.
- `rom_addr`  out  4: current micro-PC.
- `ie`, `we`, `rae`, `rbe`, `oe`, `done`  out  1 each: decoded control bits.
- `wa`, `raa`, `rba`  out  2 each: register addresses.
- `alusel`  out  3: ALU function select.
- `sh`  out  2: shifter select.
- `busy`  out  1: current word is not a WAIT word.
- `err`  out  1: sticky illegal-opcode flag.
- `timeout`  out  1: sticky watchdog-abort flag.

## Operation
- Microword fields:
  - bi = q[23:21], ba = q[20:17], ie = [16], we = [15], wa = [14:13]
  - rae = [12], raa = [11:10], rbe = [9], rba = [8:7]
  - alusel = [6:4], sh = [3:2], oe = [1], done = [0]
- Next-upc by bi:
  - 0 NEXT: upc+1, wraps 15→0.
  - 1 WAIT: ba if start edge, else hold.
  - 2 BNZ: ba if !alu_zero, else upc+1.
  - 3 RST: 0.
  - 4 B: ba.
  - 5 BN: ba if alu_neg, else upc+1.
  - 6/7: illegal; go to 0 and set err.
- Start edge = start & ~start_q. start_q is registered every cycle, including during halt.
  - Edges arriving while halted or busy are discarded, not queued.
- Taking a WAIT branch clears err and timeout.
- halt=1:
  - upc and the watchdog counter hold.
  - we, ie, oe, done forced 0; other fields pass through.
- Watchdog:
  - Counter increments each non-halted cycle with busy=1.
  - Counter clears whenever busy=0.
  - When counter == WDOG_MAX (WDOG_MAX≠0): next upc=0, timeout=1, counter cleared.
- Priority: rst_n > halt > watchdog abort > bi decode.
- Illegal opcode and watchdog abort in the same cycle: both flags set, upc=0.

## Timing
- One microinstruction per cycle. `rom_addr` = registered upc.
- All control outputs are combinational from `rom_q` and `halt`, valid in the same cycle. Flags are evaluated against that cycle's ALU result.
- Branch decision lands on the next rising edge.
- Reset, asynchronous, immediate:
  - upc=0, start_q=0, counter=0, err=0, timeout=0.
  - While rst_n=0: we, ie, oe, done forced 0.
- Reset asserted mid-run: current word abandoned, no write. After release, execution starts at addr 0.
- With start held high through reset release, the first WAIT does not fire until start falls and rises again.

## Structure
- Package `gcd_ucode_pkg`:
  - bi enum: NEXT, WAIT, BNZ, RST, B, BN.
  - Field bit-position localparams.
  - Packed struct for the 24-bit microword.
- Sub-module `gcd_ucode_decode`: purely combinational field split plus halt/reset gating. The sequencer instantiates it.

## Test plan
- rst_n low while upc=5 → rom_addr=0, we=0, err=0, timeout=0 in the same cycle, before any clock edge.
- addr0 = {bi=1, ba=1}, start held high from reset → upc stays 0. Drop start, then raise it → upc=1 one edge later.
- addr3 = {bi=2, ba=5}:
  - alu_zero=0 → upc=5; alu_zero=1 → upc=4.
  - Then addr5 = {bi=5, ba=7}: alu_neg=1 → 7; alu_neg=0 → 6.
- addr2 = {bi=6} → upc=0, err=1. err remains 1 until the next taken WAIT, then clears.
- WDOG_MAX=8, addr3 = {bi=4, ba=3} self-loop → after 8 busy cycles upc=0 and timeout=1. Repeat with halt pulses inserted → abort delayed by exactly the halted cycles.
- Full GCD microprogram with ROM + datapath, a=12, b=8 → done=1 and oe=1 at addr4 with output 4. Halt for 5 cycles at addr3 → same result, 5 cycles later, no writes while halted.

Source files
------------

// File: rtl/gcd_ucode_pkg.sv
// gcd_ucode_pkg
// Shared definitions for the GCD microprogram sequencer: branch opcodes,
// microword field positions and the packed microword layout.
package gcd_ucode_pkg;

  localparam int UW_W     = 24;
  localparam int UPC_W    = 4;

  localparam int BI_MSB   = 23;
  localparam int BI_LSB   = 21;
  localparam int BA_MSB   = 20;
  localparam int BA_LSB   = 17;
  localparam int IE_BIT   = 16;
  localparam int WE_BIT   = 15;
  localparam int WA_MSB   = 14;
  localparam int WA_LSB   = 13;
  localparam int RAE_BIT  = 12;
  localparam int RAA_MSB  = 11;
  localparam int RAA_LSB  = 10;
  localparam int RBE_BIT  = 9;
  localparam int RBA_MSB  = 8;
  localparam int RBA_LSB  = 7;
  localparam int ALU_MSB  = 6;
  localparam int ALU_LSB  = 4;
  localparam int SH_MSB   = 3;
  localparam int SH_LSB   = 2;
  localparam int OE_BIT   = 1;
  localparam int DONE_BIT = 0;

  typedef enum logic [2:0] {
    BI_NEXT = 3'd0,
    BI_WAIT = 3'd1,
    BI_BNZ  = 3'd2,
    BI_RST  = 3'd3,
    BI_B    = 3'd4,
    BI_BN   = 3'd5
  } bi_e;

  // bi is kept as raw bits so the illegal codes 6/7 stay representable.
  typedef struct packed {
    logic [2:0]       bi;
    logic [UPC_W-1:0] ba;
    logic             ie;
    logic             we;
    logic [1:0]       wa;
    logic             rae;
    logic [1:0]       raa;
    logic             rbe;
    logic [1:0]       rba;
    logic [2:0]       alusel;
    logic [1:0]       sh;
    logic             oe;
    logic             done;
  } ucode_t;

  // Codes 6 and 7 are the only ones with both upper bits set.
  function automatic logic bi_legal(input logic [2:0] bi);
    return !(bi[2] && bi[1]);
  endfunction

endpackage

// File: rtl/gcd_ucode_decode.sv
// gcd_ucode_decode
// Splits a raw microword into its fields and suppresses the side-effecting
// controls (ie, we, oe, done) while halted or in reset.
// Ports:
//   i_q     in  24  raw microword from the ROM
//   i_halt  in  1   freeze request
//   i_rst_n in  1   active-low reset (level, used only for gating)
//   o_uw    out     decoded, gated microword
module gcd_ucode_decode
  import gcd_ucode_pkg::*;
(
  input  logic [UW_W-1:0] i_q,
  input  logic            i_halt,
  input  logic            i_rst_n,
  output ucode_t          o_uw
);

  logic w_block;

  assign w_block = i_halt | ~i_rst_n;

  always_comb begin
    o_uw        = '0;
    o_uw.bi     = i_q[BI_MSB:BI_LSB];
    o_uw.ba     = i_q[BA_MSB:BA_LSB];
    o_uw.ie     = i_q[IE_BIT]   & ~w_block;
    o_uw.we     = i_q[WE_BIT]   & ~w_block;
    o_uw.wa     = i_q[WA_MSB:WA_LSB];
    o_uw.rae    = i_q[RAE_BIT];
    o_uw.raa    = i_q[RAA_MSB:RAA_LSB];
    o_uw.rbe    = i_q[RBE_BIT];
    o_uw.rba    = i_q[RBA_MSB:RBA_LSB];
    o_uw.alusel = i_q[ALU_MSB:ALU_LSB];
    o_uw.sh     = i_q[SH_MSB:SH_LSB];
    o_uw.oe     = i_q[OE_BIT]   & ~w_block;
    o_uw.done   = i_q[DONE_BIT] & ~w_block;
  end

endmodule

// File: rtl/gcd_useq.sv
// gcd_useq
// Microprogram sequencer for the GCD datapath. Holds the micro-PC that
// addresses the microcode ROM, decodes the returned word into datapath
// controls and resolves the next address from start / ALU flags. Adds a
// start edge detector, halt, illegal-opcode flag and a busy watchdog.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, halt                 run request (edge), freeze
//   alu_zero, alu_neg           same-cycle ALU flags
//   rom_q / rom_addr            microword in, micro-PC out
//   ie we rae rbe oe done       decoded control bits
//   wa raa rba alusel sh        decoded address / select fields
//   busy                        current word is not WAIT
//   err, timeout                sticky illegal-opcode / watchdog flags
//
// bi   | meaning
// NEXT | upc+1 (wraps)
// WAIT | idle; jump to ba on start edge, clears err/timeout
// BNZ  | ba if !alu_zero else upc+1
// RST  | go to 0
// B    | ba
// BN   | ba if alu_neg else upc+1
// 6/7  | illegal: go to 0, set err
module gcd_useq
  import gcd_ucode_pkg::*;
#(
  parameter int WDOG_MAX = 255
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic [UW_W-1:0]  rom_q,
  output logic [UPC_W-1:0] rom_addr,
  output logic             ie,
  output logic             we,
  output logic             rae,
  output logic             rbe,
  output logic             oe,
  output logic             done,
  output logic [1:0]       wa,
  output logic [1:0]       raa,
  output logic [1:0]       rba,
  output logic [2:0]       alusel,
  output logic [1:0]       sh,
  output logic             busy,
  output logic             err,
  output logic             timeout
);

  localparam int CW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

  ucode_t           w_uw;
  logic [UPC_W-1:0] r_upc, w_upc_nxt, w_upc_inc;
  logic             r_start_q;
  logic             r_armed;
  logic [CW-1:0]    r_wdog, w_wdog_nxt;
  logic             r_err, w_err_nxt;
  logic             r_timeout, w_to_nxt;
  logic             w_start_edge;
  logic             w_busy;
  logic             w_abort;

  gcd_ucode_decode u_decode (
    .i_q     (rom_q),
    .i_halt  (halt),
    .i_rst_n (rst_n),
    .o_uw    (w_uw)
  );

  // r_armed stays low until start has been seen low once after reset, so a
  // start level held through reset release is not mistaken for an edge.
  assign w_start_edge = start & ~r_start_q & r_armed;
  assign w_busy       = (w_uw.bi != BI_WAIT);
  assign w_abort      = (WDOG_MAX != 0) && w_busy && (r_wdog == CW'(WDOG_MAX));
  assign w_upc_inc    = r_upc + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upc     <= '0;
      r_start_q <= 1'b0;
      r_armed   <= 1'b0;
      r_wdog    <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_upc     <= w_upc_nxt;
      r_start_q <= start;
      if (!start) r_armed <= 1'b1;
      r_wdog    <= w_wdog_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  always_comb begin
    w_upc_nxt  = r_upc;
    w_wdog_nxt = r_wdog;
    w_err_nxt  = r_err;
    w_to_nxt   = r_timeout;
    if (!halt) begin
      if (!bi_legal(w_uw.bi)) begin
        w_upc_nxt = '0;
        w_err_nxt = 1'b1;
      end else begin
        case (w_uw.bi)
          BI_NEXT: w_upc_nxt = w_upc_inc;
          BI_WAIT: begin
            if (w_start_edge) begin
              w_upc_nxt = w_uw.ba;
              w_err_nxt = 1'b0;
              w_to_nxt  = 1'b0;
            end
          end
          BI_BNZ:  w_upc_nxt = alu_zero ? w_upc_inc : w_uw.ba;
          BI_RST:  w_upc_nxt = '0;
          BI_B:    w_upc_nxt = w_uw.ba;
          BI_BN:   w_upc_nxt = alu_neg ? w_uw.ba : w_upc_inc;
          default: w_upc_nxt = '0;
        endcase
      end
      // Abort overrides the branch target but leaves a same-cycle err set.
      if (!w_busy) begin
        w_wdog_nxt = '0;
      end else if (w_abort) begin
        w_upc_nxt  = '0;
        w_to_nxt   = 1'b1;
        w_wdog_nxt = '0;
      end else begin
        w_wdog_nxt = r_wdog + 1'b1;
      end
    end
  end

  assign rom_addr = r_upc;
  assign ie       = w_uw.ie;
  assign we       = w_uw.we;
  assign rae      = w_uw.rae;
  assign rbe      = w_uw.rbe;
  assign oe       = w_uw.oe;
  assign done     = w_uw.done;
  assign wa       = w_uw.wa;
  assign raa      = w_uw.raa;
  assign rba      = w_uw.rba;
  assign alusel   = w_uw.alusel;
  assign sh       = w_uw.sh;
  assign busy     = w_busy;
  assign err      = r_err;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_gcd_useq.sv
// tb_gcd_useq
// Directed bench: u_dut1 (WDOG_MAX=8) runs with bench-programmed ROM words
// and directly driven ALU flags; u_dut2 (default watchdog) runs a full GCD
// microprogram against a small register-file/ALU model.
module tb_gcd_useq;

  localparam logic [2:0] NEXT = 3'd0, WAIT = 3'd1, BNZ = 3'd2, RST = 3'd3,
                         B = 3'd4, BN = 3'd5;

  logic clk = 1'b0;
  logic rst_n, start, halt;
  int   checks = 0;
  int   errors = 0;

  // DUT 1
  logic        az1, an1;
  logic [23:0] rom1 [16];
  logic [23:0] q1;
  logic [3:0]  a1;
  logic        ie1, we1, rae1, rbe1, oe1, done1, busy1, err1, to1;
  logic [1:0]  wa1, raa1, rba1, sh1;
  logic [2:0]  alu1;

  // DUT 2 + datapath model
  logic        az2, an2;
  logic [23:0] rom2 [16];
  logic [23:0] q2;
  logic [3:0]  a2;
  logic        ie2, we2, rae2, rbe2, oe2, done2, busy2, err2, to2;
  logic [1:0]  wa2, raa2, rba2, sh2;
  logic [2:0]  alu2;
  logic [7:0]  rf [4];
  logic [7:0]  va, vb, alu_y, din, wd, dout;
  logic [7:0]  op_a = 8'd12;
  logic [7:0]  op_b = 8'd8;

  always #5 clk = ~clk;

  assign q1 = rom1[a1];
  assign q2 = rom2[a2];

  gcd_useq #(.WDOG_MAX(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .alu_zero(az1), .alu_neg(an1), .rom_q(q1), .rom_addr(a1),
    .ie(ie1), .we(we1), .rae(rae1), .rbe(rbe1), .oe(oe1), .done(done1),
    .wa(wa1), .raa(raa1), .rba(rba1), .alusel(alu1), .sh(sh1),
    .busy(busy1), .err(err1), .timeout(to1)
  );

  gcd_useq u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .alu_zero(az2), .alu_neg(an2), .rom_q(q2), .rom_addr(a2),
    .ie(ie2), .we(we2), .rae(rae2), .rbe(rbe2), .oe(oe2), .done(done2),
    .wa(wa2), .raa(raa2), .rba(rba2), .alusel(alu2), .sh(sh2),
    .busy(busy2), .err(err2), .timeout(to2)
  );

  // alusel: 0 A, 1 A-B, 2 A+B, 3 B
  always_comb begin
    va    = rae2 ? rf[raa2] : 8'd0;
    vb    = rbe2 ? rf[rba2] : 8'd0;
    alu_y = va;
    case (alu2)
      3'd1:    alu_y = va - vb;
      3'd2:    alu_y = va + vb;
      3'd3:    alu_y = vb;
      default: alu_y = va;
    endcase
    din  = (a2 == 4'd1) ? op_a : op_b;
    wd   = ie2 ? din : alu_y;
    dout = oe2 ? alu_y : 8'd0;
  end

  assign az2 = (alu_y == 8'd0);
  assign an2 = alu_y[7];

  always @(posedge clk) if (we2) rf[wa2] <= wd;

  function automatic logic [16:0] cw(input logic ie, input logic we,
      input logic [1:0] wa, input logic rae, input logic [1:0] raa,
      input logic rbe, input logic [1:0] rba, input logic [2:0] alusel,
      input logic oe, input logic dn);
    return {ie, we, wa, rae, raa, rbe, rba, alusel, 2'b00, oe, dn};
  endfunction

  function automatic logic [23:0] mw(input logic [2:0] bi, input logic [3:0] ba,
                                     input logic [16:0] c);
    return {bi, ba, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_rom1(input logic [23:0] w);
    for (int i = 0; i < 16; i++) rom1[i] = w;
  endtask

  task automatic do_reset(input logic st);
    halt  = 1'b0;
    start = st;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_rom1(mw(NEXT, 4'd0, 17'h1FFFF));
    start = 1'b0; halt = 1'b0; az1 = 1'b0; an1 = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (a1 !== 4'd0) begin errors++; $display("FAIL rst_init_addr got %0d exp 0", a1); end
    checks++; if (we1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL rst_init_gate we=%b done=%b exp 0", we1, done1); end
    checks++; if (err1 !== 1'b0 || to1 !== 1'b0) begin errors++; $display("FAIL rst_init_flags err=%b to=%b exp 0", err1, to1); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (a1 !== 4'd5) begin errors++; $display("FAIL run_to_5 got %0d exp 5", a1); end
    checks++; if (we1 !== 1'b1) begin errors++; $display("FAIL run_we got %b exp 1", we1); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a1 !== 4'd0) begin errors++; $display("FAIL rst_mid_addr got %0d exp 0", a1); end
    checks++; if (we1 !== 1'b0 || oe1 !== 1'b0) begin errors++; $display("FAIL rst_mid_gate we=%b oe=%b exp 0", we1, oe1); end
    checks++; if (err1 !== 1'b0 || to1 !== 1'b0) begin errors++; $display("FAIL rst_mid_flags err=%b to=%b exp 0", err1, to1); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_start_edge();
    fill_rom1(mw(RST, 4'd0, 17'h0));
    rom1[0] = mw(WAIT, 4'd1, 17'h0);
    rom1[1] = mw(WAIT, 4'd1, 17'h0);
    do_reset(1'b1);
    step();
    checks++; if (a1 !== 4'd0) begin errors++; $display("FAIL held_start got %0d exp 0", a1); end
    start = 1'b0;
    step();
    checks++; if (a1 !== 4'd0) begin errors++; $display("FAIL start_low got %0d exp 0", a1); end
    start = 1'b1;
    step();
    checks++; if (a1 !== 4'd1) begin errors++; $display("FAIL start_rise got %0d exp 1", a1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL wait_busy got %b exp 0", busy1); end
    start = 1'b0;
    step();
    halt  = 1'b1;
    start = 1'b1;
    step();
    halt = 1'b0;
    step();
    checks++; if (a1 !== 4'd1) begin errors++; $display("FAIL halted_edge_dropped got %0d exp 1", a1); end
    start = 1'b0;
    step();
  endtask

  task automatic test_branches();
    fill_rom1(mw(RST, 4'd0, 17'h0));
    rom1[0] = mw(WAIT, 4'd3, 17'h0);
    rom1[3] = mw(BNZ, 4'd5, 17'h1FFFF);
    rom1[4] = mw(WAIT, 4'd3, 17'h0);
    rom1[5] = mw(BN, 4'd7, 17'h0);
    rom1[6] = mw(WAIT, 4'd3, 17'h0);
    rom1[7] = mw(WAIT, 4'd3, 17'h0);
    az1 = 1'b0; an1 = 1'b0;
    do_reset(1'b0);
    pulse_start();
    checks++; if (a1 !== 4'd3 || busy1 !== 1'b1) begin errors++; $display("FAIL goto3 addr=%0d busy=%b exp 3/1", a1, busy1); end
    halt = 1'b1;
    #1;
    checks++; if ({we1, ie1, oe1, done1} !== 4'b0000) begin errors++; $display("FAIL halt_gate got %b exp 0000", {we1, ie1, oe1, done1}); end
    checks++; if (raa1 !== 2'd3 || alu1 !== 3'd7) begin errors++; $display("FAIL halt_pass raa=%0d alu=%0d exp 3/7", raa1, alu1); end
    step();
    checks++; if (a1 !== 4'd3) begin errors++; $display("FAIL halt_hold got %0d exp 3", a1); end
    halt = 1'b0;
    #1;
    checks++; if (we1 !== 1'b1) begin errors++; $display("FAIL unhalt_we got %b exp 1", we1); end
    step();
    checks++; if (a1 !== 4'd5) begin errors++; $display("FAIL bnz_taken got %0d exp 5", a1); end
    an1 = 1'b1;
    step();
    checks++; if (a1 !== 4'd7) begin errors++; $display("FAIL bn_taken got %0d exp 7", a1); end
    an1 = 1'b0;
    pulse_start();
    az1 = 1'b1;
    step();
    checks++; if (a1 !== 4'd4) begin errors++; $display("FAIL bnz_fall got %0d exp 4", a1); end
    az1 = 1'b0;
    pulse_start();
    step();
    checks++; if (a1 !== 4'd5) begin errors++; $display("FAIL bnz_taken2 got %0d exp 5", a1); end
    step();
    checks++; if (a1 !== 4'd6) begin errors++; $display("FAIL bn_fall got %0d exp 6", a1); end
  endtask

  task automatic test_illegal();
    fill_rom1(mw(RST, 4'd0, 17'h0));
    rom1[0] = mw(WAIT, 4'd1, 17'h0);
    rom1[1] = mw(NEXT, 4'd0, 17'h0);
    rom1[2] = mw(3'd6, 4'd9, 17'h0);
    do_reset(1'b0);
    pulse_start();
    step();
    checks++; if (a1 !== 4'd2 || err1 !== 1'b0) begin errors++; $display("FAIL pre_illegal addr=%0d err=%b exp 2/0", a1, err1); end
    step();
    checks++; if (a1 !== 4'd0 || err1 !== 1'b1) begin errors++; $display("FAIL illegal6 addr=%0d err=%b exp 0/1", a1, err1); end
    step(); step();
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err1); end
    rom1[2] = mw(3'd7, 4'd9, 17'h0);
    pulse_start();
    checks++; if (a1 !== 4'd1 || err1 !== 1'b0) begin errors++; $display("FAIL wait_clears_err addr=%0d err=%b exp 1/0", a1, err1); end
    step(); step();
    checks++; if (a1 !== 4'd0 || err1 !== 1'b1) begin errors++; $display("FAIL illegal7 addr=%0d err=%b exp 0/1", a1, err1); end
    rst_n = 1'b0;
    #1;
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL rst_clears_err got %b exp 0", err1); end
    do_reset(1'b0);
  endtask

  task automatic test_watchdog();
    fill_rom1(mw(RST, 4'd0, 17'h0));
    rom1[0] = mw(WAIT, 4'd3, 17'h0);
    rom1[3] = mw(B, 4'd3, 17'h0);
    do_reset(1'b0);
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (a1 !== 4'd3 || to1 !== 1'b0) begin errors++; $display("FAIL wdog_loop%0d addr=%0d to=%b exp 3/0", i, a1, to1); end
    end
    step();
    checks++; if (a1 !== 4'd0 || to1 !== 1'b1) begin errors++; $display("FAIL wdog_abort addr=%0d to=%b exp 0/1", a1, to1); end
  endtask

  task automatic test_watchdog_halt();
    logic [3:0] exp_a;
    pulse_start();
    checks++; if (a1 !== 4'd3 || to1 !== 1'b0) begin errors++; $display("FAIL wdh_entry addr=%0d to=%b exp 3/0", a1, to1); end
    for (int s = 1; s <= 12; s++) begin
      halt = (s >= 5 && s <= 7);
      step();
      exp_a = (s == 12) ? 4'd0 : 4'd3;
      checks++; if (a1 !== exp_a) begin errors++; $display("FAIL wdh_step%0d got %0d exp %0d", s, a1, exp_a); end
    end
    halt = 1'b0;
    checks++; if (to1 !== 1'b1) begin errors++; $display("FAIL wdh_timeout got %b exp 1", to1); end
    rst_n = 1'b0;
    #1;
    checks++; if (to1 !== 1'b0) begin errors++; $display("FAIL rst_clears_to got %b exp 0", to1); end
    do_reset(1'b0);
  endtask

  task automatic load_gcd();
    for (int i = 0; i < 16; i++) rom2[i] = mw(RST, 4'd0, 17'h0);
    rom2[0] = mw(WAIT, 4'd1, 17'h0);
    rom2[1] = mw(NEXT, 4'd0, cw(1, 1, 2'd0, 0, 2'd0, 0, 2'd0, 3'd0, 0, 0));
    rom2[2] = mw(NEXT, 4'd0, cw(1, 1, 2'd1, 0, 2'd0, 0, 2'd0, 3'd0, 0, 0));
    rom2[3] = mw(BNZ,  4'd5, cw(0, 0, 2'd0, 1, 2'd0, 1, 2'd1, 3'd1, 0, 0));
    rom2[4] = mw(WAIT, 4'd1, cw(0, 0, 2'd0, 1, 2'd0, 0, 2'd0, 3'd0, 1, 1));
    rom2[5] = mw(BN,   4'd7, cw(0, 0, 2'd0, 1, 2'd0, 1, 2'd1, 3'd1, 0, 0));
    rom2[6] = mw(B,    4'd3, cw(0, 1, 2'd0, 1, 2'd0, 1, 2'd1, 3'd1, 0, 0));
    rom2[7] = mw(B,    4'd3, cw(0, 1, 2'd1, 1, 2'd1, 1, 2'd0, 3'd1, 0, 0));
  endtask

  task automatic test_gcd();
    int n;
    do_reset(1'b0);
    start = 1'b1;
    n = 0;
    while (done2 !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    start = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL gcd_cycles got %0d exp 10", n); end
    checks++; if (a2 !== 4'd4 || oe2 !== 1'b1) begin errors++; $display("FAIL gcd_done_state addr=%0d oe=%b exp 4/1", a2, oe2); end
    checks++; if (dout !== 8'd4) begin errors++; $display("FAIL gcd_result got %0d exp 4", dout); end
  endtask

  task automatic test_gcd_halt();
    int n;
    int hc;
    do_reset(1'b0);
    start = 1'b1;
    n  = 0;
    hc = 0;
    while (done2 !== 1'b1 && n < 60) begin
      step();
      n++;
      if (a2 == 4'd3 && hc < 5) begin
        halt = 1'b1;
        hc++;
        #1;
        checks++; if (we2 !== 1'b0) begin errors++; $display("FAIL gcdh_we got %b exp 0", we2); end
      end else if (halt) begin
        halt = 1'b0;
        checks++; if (a2 !== 4'd3 || rf[0] !== 8'd12 || rf[1] !== 8'd8) begin errors++; $display("FAIL gcdh_frozen addr=%0d r0=%0d r1=%0d exp 3/12/8", a2, rf[0], rf[1]); end
      end
    end
    halt  = 1'b0;
    start = 1'b0;
    checks++; if (n != 15) begin errors++; $display("FAIL gcdh_cycles got %0d exp 15", n); end
    checks++; if (dout !== 8'd4 || done2 !== 1'b1) begin errors++; $display("FAIL gcdh_result out=%0d done=%b exp 4/1", dout, done2); end
  endtask

  initial begin
    start = 1'b0; halt = 1'b0; rst_n = 1'b0; az1 = 1'b0; an1 = 1'b0;
    load_gcd();
    test_reset();
    test_start_edge();
    test_branches();
    test_illegal();
    test_watchdog();
    test_watchdog_halt();
    test_gcd();
    test_gcd_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

endmodule
